conv_layer_sequencer: RTL

Frame-level controller for one 16-channel 3x3 conv feature-map engine. It starts a layer pass on command and issues one common read strobe to all per-channel input FIFOs, but only when every channel has data and the downstream buffer has room. It counts padded input pixels and produced output pixels, then reports completion or a stall error to the layer scheduler above it.

---
 rtl/conv_seq_pkg.sv | 35 +++
 rtl/conv_layer_sequencer_sat_counter.sv | 40 ++++
 rtl/conv_layer_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// -----------------------------------------------------------------------------
// conv_seq_pkg
// Shared definitions for the conv layer sequencer:
//   - state_t     : frame FSM state (IDLE / STREAM / DRAIN / DONE)
//   - clog2       : ceiling log2, used to size counters from parameters
//   - in_total    : padded input pixels per frame, (width+2)^2
//   - out_total   : output pixels per frame, width^2
// -----------------------------------------------------------------------------
package conv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int in_total(input int width);
        return (width + 2) * (width + 2);
    endfunction

    function automatic int out_total(input int width);
        return width * width;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at LIMIT.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear (beats i_inc)
//   i_inc    : count one; ignored once the count equals LIMIT
//   o_cnt    : current count
//   o_sat    : high while o_cnt == LIMIT
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == LIM);

endmodule

// File: rtl/conv_layer_sequencer.sv
// -----------------------------------------------------------------------------
// conv_layer_sequencer
// Frame controller for a 16-channel 3x3 conv feature-map engine. On start it
// streams (WIDTH+2)^2 padded pixels out of the per-channel input FIFOs with a
// single common read strobe, counts engine output pixels, and finishes with a
// one-cycle done pulse (or a sticky error if the engine goes quiet in DRAIN).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle frame start, honoured only in IDLE
//   fifo_empty        : per-channel empty flags (show-ahead FIFOs)
//   out_almost_full   : downstream cannot accept new work
//   conv_valid_out    : one pulse per output pixel from the engine
//   rdreq             : common read strobe to all FIFOs / engine valid_in
//   busy              : high in STREAM or DRAIN
//   done              : one-cycle pulse at frame completion
//   err               : sticky error, cleared by start or rst
//   in_cnt, out_cnt   : padded pixels read / output pixels seen this frame
//   o_dbg_state       : current FSM state (state_t encoding)
//
// Read handshake: rdreq acts as "ready" against the FIFOs' "valid" (~empty).
// A pixel transfers on exactly the cycles where rdreq is high; rdreq is only
// raised when every channel is non-empty and downstream has room, so all
// channels always pop together and no pixel is ever lost or duplicated.
// -----------------------------------------------------------------------------
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int WIDTH         = 56,
    parameter int NUM_CH        = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int IN_CNT_W      = clog2(in_total(WIDTH) + 1),
    parameter int OUT_CNT_W     = clog2(out_total(WIDTH) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    fifo_empty,
    input  logic                 out_almost_full,
    input  logic                 conv_valid_out,
    output logic                 rdreq,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IN_CNT_W-1:0]  in_cnt,
    output logic [OUT_CNT_W-1:0] out_cnt,
    output logic [1:0]           o_dbg_state
);

    localparam int IN_TOTAL  = in_total(WIDTH);
    localparam int OUT_TOTAL = out_total(WIDTH);
    localparam int TMO_W     = clog2(DRAIN_TIMEOUT + 1);

    localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(IN_TOTAL - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_TOTAL - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

    state_t r_state;
    logic   r_busy;
    logic   r_done;
    logic   r_err;

    logic [IN_CNT_W-1:0]  w_in_cnt;
    logic [OUT_CNT_W-1:0] w_out_cnt;
    logic [TMO_W-1:0]     w_tmo_cnt;
    logic w_in_sat, w_out_sat, w_tmo_sat;
    logic w_active, w_start_ok, w_rdreq, w_last_read;
    logic w_out_inc, w_out_hit, w_tmo_inc, w_tmo_clr, w_tmo_hit, w_valid_err;

    assign w_active   = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
    assign w_start_ok = start && (r_state == ST_IDLE);

    assign w_rdreq     = (r_state == ST_STREAM) && !(|fifo_empty)
                         && !out_almost_full && !w_in_sat;
    assign w_last_read = w_rdreq && (w_in_cnt == IN_LAST);

    // Completion is judged on the count as it will be after this cycle, so
    // the valid that fills out_cnt yields done on the very next cycle.
    assign w_out_inc = conv_valid_out && w_active;
    assign w_out_hit = w_out_sat || (w_out_inc && (w_out_cnt == OUT_LAST));

    // The timeout counter holds zero outside DRAIN and after each valid, and
    // counts idle DRAIN cycles. The frame is abandoned on the cycle that
    // would be the DRAIN_TIMEOUT-th consecutive idle one.
    assign w_tmo_inc = (r_state == ST_DRAIN) && !conv_valid_out;
    assign w_tmo_clr = (r_state != ST_DRAIN) || conv_valid_out;
    assign w_tmo_hit = w_tmo_sat || (w_tmo_inc && (w_tmo_cnt == TMO_LAST));

    // A valid with no frame running, or beyond the frame's pixel count.
    assign w_valid_err = conv_valid_out && (!w_active || w_out_sat);

    sat_counter #(.W(IN_CNT_W), .LIMIT(IN_TOTAL)) u_in_cnt (
        .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_inc(w_rdreq),
        .o_cnt(w_in_cnt), .o_sat(w_in_sat)
    );

    sat_counter #(.W(OUT_CNT_W), .LIMIT(OUT_TOTAL)) u_out_cnt (
        .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_inc(w_out_inc),
        .o_cnt(w_out_cnt), .o_sat(w_out_sat)
    );

    sat_counter #(.W(TMO_W), .LIMIT(DRAIN_TIMEOUT)) u_tmo_cnt (
        .clk(clk), .rst(rst), .i_clr(w_tmo_clr), .i_inc(w_tmo_inc),
        .o_cnt(w_tmo_cnt), .o_sat(w_tmo_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_STREAM;
                        r_busy  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_last_read) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_hit || w_tmo_hit) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A start clears err, but a stray valid in the same cycle still
            // flags it (later assignment wins).
            if (w_start_ok) begin
                r_err <= 1'b0;
            end
            if (w_valid_err || ((r_state == ST_DRAIN) && !w_out_hit && w_tmo_hit)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rdreq       = w_rdreq;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign in_cnt      = w_in_cnt;
    assign out_cnt     = w_out_cnt;
    assign o_dbg_state = r_state;

endmodule
